// File: rtl/alignment_decoder.sv
// Alignment decoder: turns a traceback coordinate stream into aligned
// character pairs and keeps a running alignment score.
module alignment_decoder #(
  parameter int LENGTH = 10,
  parameter int CWIDTH = 2,
  parameter int CORD_LENGTH = 8,
  parameter int SWIDTH = 16,
  parameter int signed MATCH = 1,
  parameter int signed MISMATCH = -1,
  parameter int signed INDEL = -1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [LENGTH*CWIDTH-1:0]   s1,
  input  logic [LENGTH*CWIDTH-1:0]   s2,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*CORD_LENGTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CWIDTH-1:0]          out_c1,
  output logic [CWIDTH-1:0]          out_c2,
  output logic                       out_gap1,
  output logic                       out_gap2,
  output logic                       out_last,
  output logic [SWIDTH-1:0]          score,
  output logic                       done,
  output logic                       error
);

  typedef enum logic [2:0] {
    IDLE, HOLD, EMIT, FINAL, DONE, ERR
  } state_t;

  localparam logic [CORD_LENGTH-1:0] TOP =
    CORD_LENGTH'(LENGTH - 1);

  state_t state;

  logic [CORD_LENGTH-1:0] px, py;
  logic [CORD_LENGTH-1:0] nx, ny;
  logic [CORD_LENGTH-1:0] wx, wy;
  logic in_fire, out_fire;
  logic dx1, dx0, dy1, dy0;
  logic is_diag, is_g1, is_g2;
  int   step;

  function automatic logic [CWIDTH-1:0] pick(
    input logic [LENGTH*CWIDTH-1:0] s,
    input logic [CORD_LENGTH-1:0]   i
  );
    logic [LENGTH*CWIDTH-1:0] t;
    t = s >> (CWIDTH * (LENGTH - 1 - int'(i)));
    return t[CWIDTH-1:0];
  endfunction

  assign wx = in_data[2*CORD_LENGTH-1:CORD_LENGTH];
  assign wy = in_data[CORD_LENGTH-1:0];

  assign in_ready  = (state == IDLE) || (state == HOLD)
                  || (state == ERR);
  assign out_valid = (state == EMIT) || (state == FINAL);
  assign done      = (state == DONE);
  assign error     = (state == ERR);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Step classification: each coordinate may only stay or drop by one;
  // the zero guard stops a wrap from 0 to all-ones looking like a step.
  always_comb begin
    dx1 = (px != '0) && (wx == px - 1'b1);
    dy1 = (py != '0) && (wy == py - 1'b1);
    dx0 = (wx == px);
    dy0 = (wy == py);
    is_diag = dx1 && dy1;
    is_g1   = dx1 && dy0;
    is_g2   = dx0 && dy1;
  end

  // Score weight of the pair currently on the output.
  always_comb begin
    step = MISMATCH;
    if (out_gap1 || out_gap2)
      step = INDEL;
    else if (out_c1 == out_c2)
      step = MATCH;
  end

  // Main control FSM with registered pair and score.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      px       <= '0;
      py       <= '0;
      nx       <= '0;
      ny       <= '0;
      score    <= '0;
      out_c1   <= '0;
      out_c2   <= '0;
      out_gap1 <= 1'b0;
      out_gap2 <= 1'b0;
      out_last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          if (wx == TOP && wy == TOP) begin
            px    <= wx;
            py    <= wy;
            state <= HOLD;
          end else begin
            state <= ERR;
          end
        end
        HOLD: if (in_fire) begin
          nx       <= wx;
          ny       <= wy;
          out_last <= 1'b0;
          unique case (1'b1)
            is_diag: begin
              out_c1   <= pick(s1, py);
              out_c2   <= pick(s2, px);
              out_gap1 <= 1'b0;
              out_gap2 <= 1'b0;
              state    <= EMIT;
            end
            is_g1: begin
              out_c1   <= '0;
              out_c2   <= pick(s2, px);
              out_gap1 <= 1'b1;
              out_gap2 <= 1'b0;
              state    <= EMIT;
            end
            is_g2: begin
              out_c1   <= pick(s1, py);
              out_c2   <= '0;
              out_gap1 <= 1'b0;
              out_gap2 <= 1'b1;
              state    <= EMIT;
            end
            default: state <= ERR;
          endcase
        end
        EMIT: if (out_fire) begin
          score <= score + SWIDTH'(step);
          px    <= nx;
          py    <= ny;
          if (nx == '0 && ny == '0) begin
            out_c1   <= pick(s1, '0);
            out_c2   <= pick(s2, '0);
            out_gap1 <= 1'b0;
            out_gap2 <= 1'b0;
            out_last <= 1'b1;
            state    <= FINAL;
          end else begin
            state <= HOLD;
          end
        end
        FINAL: if (out_fire) begin
          score <= score + SWIDTH'(step);
          state <= DONE;
        end
        DONE:    state <= DONE;
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_alignment_decoder.sv
// Directed bench for alignment_decoder with LENGTH=4 strings.
// Expected pairs and scores are worked out by hand from the strings.
module tb_alignment_decoder;

  localparam int L  = 4;
  localparam int CW = 2;
  localparam int CL = 8;
  localparam int SW = 16;

  logic            clk;
  logic            reset;
  logic [L*CW-1:0] s1, s2;
  logic            in_valid;
  logic            in_ready;
  logic [2*CL-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   out_c1, out_c2;
  logic            out_gap1, out_gap2, out_last;
  logic [SW-1:0]   score;
  logic            done, error;

  int checks = 0;
  int errors = 0;

  task automatic ck(input string tag, input bit ok,
                    input logic [31:0] obs,
                    input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  alignment_decoder #(
    .LENGTH(L), .CWIDTH(CW),
    .CORD_LENGTH(CL), .SWIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset),
    .s1(s1), .s2(s2),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c1(out_c1), .out_c2(out_c2),
    .out_gap1(out_gap1), .out_gap2(out_gap2),
    .out_last(out_last), .score(score),
    .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(input int x, input int y);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = {CL'(x), CL'(y)};
    ck("send_in_ready", in_ready === 1'b1, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pair(input string tag, input int c1,
                      input int c2, input bit g1,
                      input bit g2, input bit last);
    logic [7:0] obs, exp;
    obs = {1'b1 ^ out_valid, out_c1, out_c2,
           out_gap1, out_gap2, out_last};
    exp = {1'b0, CW'(c1), CW'(c2), g1, g2, last};
    ck(tag, obs === exp, obs, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_acgt();
    send(3, 3);
    send(2, 2);
    ck("lat_valid", out_valid === 1'b1, out_valid, 1);
    pair("p_d3", 3, 3, 0, 0, 0);
    send(1, 1);
    pair("p_d2", 2, 2, 0, 0, 0);
    send(0, 0);
    pair("p_d1", 1, 1, 0, 0, 0);
    pair("p_fin", 0, 0, 0, 0, 1);
    ck("acgt_done", done === 1'b1, done, 1);
    ck("acgt_score", score === 16'd4, score, 4);
    ck("acgt_in_ready", in_ready === 1'b0, in_ready, 0);
    ck("acgt_out_valid", out_valid === 1'b0,
       out_valid, 0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    s1 = 8'h1B;
    s2 = 8'h1B;

    do_reset();
    ck("rst_in_ready", in_ready === 1'b1, in_ready, 1);
    ck("rst_out_valid", out_valid === 1'b0, out_valid, 0);
    ck("rst_score", score === 16'd0, score, 0);
    ck("rst_done", done === 1'b0, done, 0);
    ck("rst_error", error === 1'b0, error, 0);

    run_acgt();
    repeat (3) @(posedge clk);
    #1;
    ck("done_hold", done === 1'b1, done, 1);
    ck("score_hold", score === 16'd4, score, 4);

    s2 = 8'hE4;
    do_reset();
    send(3, 3);
    send(2, 3);
    pair("m_g1", 0, 0, 1, 0, 0);
    send(1, 2);
    pair("m_d1", 3, 1, 0, 0, 0);
    send(0, 1);
    pair("m_d2", 2, 2, 0, 0, 0);
    send(0, 0);
    pair("m_g2", 1, 0, 0, 1, 0);
    pair("m_fin", 0, 3, 0, 0, 1);
    ck("mix_score", score === 16'hFFFD, score, 16'hFFFD);
    ck("mix_done", done === 1'b1, done, 1);

    s2 = 8'h1B;
    do_reset();
    send(2, 3);
    ck("bad_first_err", error === 1'b1, error, 1);
    ck("bad_first_ov", out_valid === 1'b0, out_valid, 0);
    ck("bad_first_rdy", in_ready === 1'b1, in_ready, 1);
    send(3, 3);
    ck("err_sticky", error === 1'b1, error, 1);
    ck("err_no_ov", out_valid === 1'b0, out_valid, 0);
    ck("err_score", score === 16'd0, score, 0);

    do_reset();
    send(3, 3);
    send(1, 3);
    ck("jump_err", error === 1'b1, error, 1);
    ck("jump_ov", out_valid === 1'b0, out_valid, 0);

    do_reset();
    send(3, 3);
    send(3, 3);
    ck("zero_delta_err", error === 1'b1, error, 1);
    ck("zero_delta_ov", out_valid === 1'b0, out_valid, 0);

    do_reset();
    send(3, 3);
    send(2, 2);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      ck("stall_valid", out_valid === 1'b1, out_valid, 1);
      ck("stall_pair",
         {out_c1, out_c2, out_gap1, out_gap2} === 6'b111100,
         {out_c1, out_c2, out_gap1, out_gap2}, 6'b111100);
      ck("stall_in_ready", in_ready === 1'b0, in_ready, 0);
      ck("stall_score", score === 16'd0, score, 0);
    end
    pair("stall_take", 3, 3, 0, 0, 0);
    ck("after_stall_ov", out_valid === 1'b0, out_valid, 0);
    ck("after_stall_rdy", in_ready === 1'b1, in_ready, 1);
    ck("after_stall_score", score === 16'd1, score, 1);

    send(1, 1);
    ck("pre_rst_ov", out_valid === 1'b1, out_valid, 1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    ck("mid_rst_ov", out_valid === 1'b0, out_valid, 0);
    ck("mid_rst_score", score === 16'd0, score, 0);
    ck("mid_rst_rdy", in_ready === 1'b1, in_ready, 1);
    ck("mid_rst_done", done === 1'b0, done, 0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b0;
    run_acgt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
